// File: rtl/pcie_msi_irq_ctrl_pkg.sv
// Shared definitions for the MSI interrupt controller.
// Holds the controller state encoding, the maximum MSI vector count,
// and the width of a vector index.
package pcie_msi_irq_ctrl_pkg;

  // Controller states, kept as plain constants so older tools can read them
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_BACKOFF = 2'd3;

  // MSI allows at most 32 vectors per function
  localparam int MAX_VEC = 32;
  localparam int VEC_W   = 5;

endpackage

// File: rtl/pcie_msi_rr_arb.sv
// Combinational round-robin priority picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts
//   grant - lowest requesting index >= ptr, else lowest requesting index
//   valid - high when any request bit is set
module pcie_msi_rr_arb
  import pcie_msi_irq_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]     req,
  input  logic [VEC_W-1:0] ptr,
  output logic [VEC_W-1:0] grant,
  output logic             valid
);

  logic             hi_found;
  logic             lo_found;
  logic [VEC_W-1:0] hi_idx;
  logic [VEC_W-1:0] lo_idx;

  // Track two candidates in one pass: the first hit at or above the
  // pointer, and the first hit overall for the wrap-around case.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = VEC_W'(i);
        end
        if (!hi_found && (i >= int'(ptr))) begin
          hi_found = 1'b1;
          hi_idx   = VEC_W'(i);
        end
      end
    end
  end

  assign grant = hi_found ? hi_idx : lo_idx;
  assign valid = lo_found;

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// MSI interrupt controller for PCIe function 0.
// Latches request pulses into pending bits, picks one eligible vector
// round-robin, drives a one-cycle one-hot msi_int, then waits for the
// core's sent/fail answer with a timeout and a retry back-off.
// Ports:
//   clk, rst               - clock, async active-high reset
//   irq                    - request pulses, bit i -> MSI vector i
//   msi_enable/mmenable    - core MSI config (function 0 bits only)
//   msi_int                - one-hot interrupt request, one cycle per issue
//   msi_sent/msi_fail      - core handshake responses
//   msi_* constants        - unused sideband fields tied to zero
//   msi_pending_status     - zero-extended copy of pending
//   pending, busy          - status
//   sent_count/fail_count  - saturating outcome counters
module pcie_msi_irq_ctrl
  import pcie_msi_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 32,
  parameter int TIMEOUT     = 1024,
  parameter int RETRY_DELAY = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic [3:0]           msi_enable,
  input  logic [11:0]          msi_mmenable,
  output logic [31:0]          msi_int,
  input  logic                 msi_sent,
  input  logic                 msi_fail,
  output logic [3:0]           msi_select,
  output logic [3:0]           msi_function_number,
  output logic [2:0]           msi_attr,
  output logic                 msi_tph_present,
  output logic [1:0]           msi_tph_type,
  output logic [8:0]           msi_tph_st_tag,
  output logic [31:0]          msi_pending_status,
  output logic                 msi_pending_status_data_enable,
  output logic [3:0]           msi_pending_status_function_num,
  output logic [NUM_IRQ-1:0]   pending,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  localparam int TMR_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [1:0]         state;
  logic [VEC_W-1:0]   cur;
  logic [VEC_W-1:0]   rr_ptr;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         n_vec;
  logic [7:0]         n_cap;
  logic [NUM_IRQ-1:0] elig_mask;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic [VEC_W-1:0]   grant;
  logic               grant_valid;
  logic [VEC_W-1:0]   next_ptr;
  logic               unused_cfg;

  // Only function 0 config bits matter; the rest are deliberately ignored
  assign unused_cfg = ^{msi_enable[3:1], msi_mmenable[11:3]};

  // Multi-message enable encodes log2 of the vector count granted by the host
  assign n_vec = 8'd1 << msi_mmenable[2:0];
  assign n_cap = (n_vec > 8'(MAX_VEC)) ? 8'(MAX_VEC) : n_vec;

  // Vectors above the granted count stay pending but are not offered
  always_comb begin
    elig_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig_mask[i] = (i < int'(n_cap));
    end
  end

  assign eligible = pending & elig_mask & {NUM_IRQ{msi_enable[0]}};

  pcie_msi_rr_arb #(.N(NUM_IRQ)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  assign next_ptr = (cur == VEC_W'(NUM_IRQ - 1)) ? '0 : cur + 1'b1;

  // A bit is cleared only on a confirmed send; irq is ORed in afterwards so
  // a request landing in the same cycle survives the clear.
  assign clr = (state == ST_WAIT && msi_sent) ?
               ({{(NUM_IRQ-1){1'b0}}, 1'b1} << cur) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | irq;
    end
  end

  // Handshake FSM; msi_int is registered so it is high only during ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur        <= '0;
      rr_ptr     <= '0;
      timer      <= '0;
      msi_int    <= '0;
      sent_count <= '0;
      fail_count <= '0;
    end else begin
      msi_int <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur     <= grant;
            msi_int <= 32'd1 << grant;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= TMR_W'(TIMEOUT);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // sent wins over a simultaneous fail
          if (msi_sent) begin
            rr_ptr <= next_ptr;
            if (sent_count != '1) sent_count <= sent_count + 1'b1;
            state <= ST_IDLE;
          end else if (msi_fail || timer <= TMR_W'(1)) begin
            rr_ptr <= next_ptr;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
            timer <= TMR_W'(RETRY_DELAY);
            state <= ST_BACKOFF;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          if (timer <= TMR_W'(1)) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  assign msi_pending_status              = 32'(pending);
  assign msi_select                      = '0;
  assign msi_function_number             = '0;
  assign msi_attr                        = '0;
  assign msi_tph_present                 = 1'b0;
  assign msi_tph_type                    = '0;
  assign msi_tph_st_tag                  = '0;
  assign msi_pending_status_data_enable  = 1'b0;
  assign msi_pending_status_function_num = '0;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Self-checking bench for pcie_msi_irq_ctrl: a cycle table for the basic
// issue path plus hand-written sequences for fail, timeout, reset and
// round-robin ordering.
module tb_pcie_msi_irq_ctrl;

  localparam int NUM_IRQ     = 32;
  localparam int TIMEOUT     = 8;
  localparam int RETRY_DELAY = 4;
  localparam int CNT_WIDTH   = 16;

  logic                 clk;
  logic                 rst;
  logic [NUM_IRQ-1:0]   irq;
  logic [3:0]           msi_enable;
  logic [11:0]          msi_mmenable;
  logic [31:0]          msi_int;
  logic                 msi_sent;
  logic                 msi_fail;
  logic [3:0]           msi_select;
  logic [3:0]           msi_function_number;
  logic [2:0]           msi_attr;
  logic                 msi_tph_present;
  logic [1:0]           msi_tph_type;
  logic [8:0]           msi_tph_st_tag;
  logic [31:0]          msi_pending_status;
  logic                 msi_pending_status_data_enable;
  logic [3:0]           msi_pending_status_function_num;
  logic [NUM_IRQ-1:0]   pending;
  logic                 busy;
  logic [CNT_WIDTH-1:0] sent_count;
  logic [CNT_WIDTH-1:0] fail_count;

  int nCompared;
  int nMismatched;
  int expSent;
  int expFail;

  typedef struct {
    logic [31:0] irq;
    logic        en;
    logic [2:0]  mm;
    logic        sent;
    logic        fail;
    logic [31:0] expInt;
    logic [31:0] expPend;
    logic        expBusy;
    int          expSent;
    int          expFail;
  } vec_t;

  vec_t vecs[21];

  pcie_msi_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ), .TIMEOUT(TIMEOUT),
    .RETRY_DELAY(RETRY_DELAY), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq),
    .msi_enable(msi_enable), .msi_mmenable(msi_mmenable),
    .msi_int(msi_int), .msi_sent(msi_sent), .msi_fail(msi_fail),
    .msi_select(msi_select), .msi_function_number(msi_function_number),
    .msi_attr(msi_attr), .msi_tph_present(msi_tph_present),
    .msi_tph_type(msi_tph_type), .msi_tph_st_tag(msi_tph_st_tag),
    .msi_pending_status(msi_pending_status),
    .msi_pending_status_data_enable(msi_pending_status_data_enable),
    .msi_pending_status_function_num(msi_pending_status_function_num),
    .pending(pending), .busy(busy),
    .sent_count(sent_count), .fail_count(fail_count)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the active edge
  task automatic applyStimulus(input vec_t v);
    irq          = v.irq;
    msi_enable   = {3'b000, v.en};
    msi_mmenable = {9'd0, v.mm};
    msi_sent     = v.sent;
    msi_fail     = v.fail;
    @(posedge clk);
    #1;
    irq      = '0;
    msi_sent = 1'b0;
    msi_fail = 1'b0;
  endtask

  task automatic pulseIrq(input logic [31:0] mask);
    irq = mask;
    @(posedge clk);
    #1;
    irq = '0;
  endtask

  // Wait (bounded) for the next msi_int pulse and compare its vector
  task automatic waitIssue(input string name, input logic [31:0] exp,
                           output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (msi_int == 32'd0 && cycles < 200);
    checkOutput(name, msi_int, exp);
  endtask

  // From the ISSUE cycle, answer sent k cycles later
  task automatic sendAfter(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    msi_sent = 1'b1;
    @(posedge clk);
    #1;
    msi_sent = 1'b0;
    expSent++;
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic e,
                              input logic [2:0] m, input logic s,
                              input logic f, input logic [31:0] xi,
                              input logic [31:0] xp, input logic xb,
                              input int xs, input int xf);
    vec_t v;
    v.irq = i; v.en = e; v.mm = m; v.sent = s; v.fail = f;
    v.expInt = xi; v.expPend = xp; v.expBusy = xb;
    v.expSent = xs; v.expFail = xf;
    return v;
  endfunction

  initial begin
    int cyc;
    bit sawInt;
    nCompared   = 0;
    nMismatched = 0;

    // Single issue with sent 3 cycles after ISSUE
    vecs[0]  = mk(32'h20, 1, 5, 0, 0, 32'h00, 32'h20, 0, 0, 0);
    vecs[1]  = mk(32'h00, 1, 5, 0, 0, 32'h20, 32'h20, 1, 0, 0);
    vecs[2]  = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h20, 1, 0, 0);
    vecs[3]  = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h20, 1, 0, 0);
    vecs[4]  = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h20, 1, 0, 0);
    vecs[5]  = mk(32'h00, 1, 5, 1, 0, 32'h00, 32'h00, 0, 1, 0);
    vecs[6]  = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h00, 0, 1, 0);
    // irq[7] re-pulsed in the cycle its sent arrives
    vecs[7]  = mk(32'h80, 1, 5, 0, 0, 32'h00, 32'h80, 0, 1, 0);
    vecs[8]  = mk(32'h00, 1, 5, 0, 0, 32'h80, 32'h80, 1, 1, 0);
    vecs[9]  = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h80, 1, 1, 0);
    vecs[10] = mk(32'h80, 1, 5, 1, 0, 32'h00, 32'h80, 0, 2, 0);
    vecs[11] = mk(32'h00, 1, 5, 0, 0, 32'h80, 32'h80, 1, 2, 0);
    vecs[12] = mk(32'h00, 1, 5, 0, 0, 32'h00, 32'h80, 1, 2, 0);
    vecs[13] = mk(32'h00, 1, 5, 1, 0, 32'h00, 32'h00, 0, 3, 0);
    // Stray sent+fail while idle must not count
    vecs[14] = mk(32'h00, 1, 5, 1, 1, 32'h00, 32'h00, 0, 3, 0);
    // Vector 4 held while only 2 vectors are enabled, issued at N=8
    vecs[15] = mk(32'h10, 1, 1, 0, 0, 32'h00, 32'h10, 0, 3, 0);
    vecs[16] = mk(32'h00, 1, 1, 0, 0, 32'h00, 32'h10, 0, 3, 0);
    vecs[17] = mk(32'h00, 1, 1, 0, 0, 32'h00, 32'h10, 0, 3, 0);
    vecs[18] = mk(32'h00, 1, 3, 0, 0, 32'h10, 32'h10, 1, 3, 0);
    vecs[19] = mk(32'h00, 1, 3, 0, 0, 32'h00, 32'h10, 1, 3, 0);
    vecs[20] = mk(32'h00, 1, 3, 1, 0, 32'h00, 32'h00, 0, 4, 0);

    rst          = 1'b1;
    irq          = '0;
    msi_enable   = 4'h1;
    msi_mmenable = 12'd5;
    msi_sent     = 1'b0;
    msi_fail     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset msi_int", msi_int, 32'd0);
    checkOutput("reset pending", pending, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset counters", {sent_count, fail_count}, 32'd0);
    checkOutput("const outputs",
                32'({msi_select, msi_function_number, msi_attr,
                     msi_tph_present, msi_tph_type, msi_tph_st_tag,
                     msi_pending_status_data_enable,
                     msi_pending_status_function_num}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d msi_int", i), msi_int, vecs[i].expInt);
      checkOutput($sformatf("row%0d pending", i), pending, vecs[i].expPend);
      checkOutput($sformatf("row%0d status", i), msi_pending_status,
                  vecs[i].expPend);
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d sent_count", i), 32'(sent_count),
                  32'(vecs[i].expSent));
      checkOutput($sformatf("row%0d fail_count", i), 32'(fail_count),
                  32'(vecs[i].expFail));
    end
    expSent = 4;
    expFail = 0;
    msi_mmenable = 12'd5;

    // Fail on vector 2, back off, reissue, then succeed
    pulseIrq(32'h4);
    waitIssue("fail issue", 32'h4, cyc);
    @(posedge clk);
    #1;
    msi_fail = 1'b1;
    @(posedge clk);
    #1;
    msi_fail = 1'b0;
    expFail++;
    checkOutput("fail_count after fail", 32'(fail_count), 32'(expFail));
    cyc = 0;
    while (msi_int == 32'd0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("backoff quiet cycles", 32'(cyc), 32'(RETRY_DELAY + 1));
    checkOutput("fail reissue", msi_int, 32'h4);
    sendAfter(2);
    checkOutput("pending after retry", pending, 32'd0);
    checkOutput("sent_count after retry", 32'(sent_count), 32'(expSent));

    // No response: two timeouts, then sent
    pulseIrq(32'h2);
    waitIssue("timeout issue", 32'h2, cyc);
    for (int t = 0; t < 2; t++) begin
      waitIssue($sformatf("timeout reissue%0d", t), 32'h2, cyc);
      expFail++;
      checkOutput($sformatf("timeout quiet%0d", t), 32'(cyc - 1),
                  32'(TIMEOUT + RETRY_DELAY + 1));
      checkOutput($sformatf("timeout fail_count%0d", t), 32'(fail_count),
                  32'(expFail));
    end
    sendAfter(1);
    checkOutput("pending after timeout", pending, 32'd0);

    // Asynchronous reset while in WAIT
    pulseIrq(32'h40);
    waitIssue("pre-reset issue", 32'h40, cyc);
    @(posedge clk);
    #1;
    checkOutput("busy in WAIT", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst pending", pending, 32'd0);
    checkOutput("async rst counters", {sent_count, fail_count}, 32'd0);
    checkOutput("async rst msi_int", msi_int, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expSent = 0;
    expFail = 0;
    sawInt = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (msi_int != 32'd0) sawInt = 1'b1;
    end
    checkOutput("no msi_int after reset", 32'(sawInt), 32'd0);

    // Round-robin order 0,3,8 then 9 ahead of 0
    pulseIrq(32'h0000_0109);
    waitIssue("rr first", 32'h1, cyc);
    sendAfter(2);
    waitIssue("rr second", 32'h8, cyc);
    sendAfter(2);
    waitIssue("rr third", 32'h100, cyc);
    sendAfter(2);
    pulseIrq(32'h0000_0201);
    waitIssue("rr wrap first", 32'h200, cyc);
    sendAfter(2);
    waitIssue("rr wrap second", 32'h1, cyc);
    sendAfter(2);
    checkOutput("rr pending", pending, 32'd0);
    checkOutput("rr sent_count", 32'(sent_count), 32'(expSent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
